// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, iteration count.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam int MDU_ITER = 32;
  localparam int CNT_W    = 6;

endpackage

// File: rtl/mdu_signfix.sv
// Operand magnitude extraction and two's-complement correction of the unsigned
// iteration result (product, or quotient/remainder).
module mdu_signfix (
  input  logic        sgn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] a_mag,
  output logic [31:0] b_mag,
  input  logic        a_neg,
  input  logic        b_neg,
  input  logic        is_div,
  input  logic [31:0] raw_hi,
  input  logic [31:0] raw_lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] prod;

  assign a_mag = (sgn && a[31]) ? -a : a;
  assign b_mag = (sgn && b[31]) ? -b : b;

  // Quotient takes the XOR of signs, remainder follows the dividend.
  always_comb begin
    prod   = {raw_hi, raw_lo};
    res_hi = raw_hi;
    res_lo = raw_lo;
    if (is_div) begin
      if (a_neg ^ b_neg) res_lo = -raw_lo;
      if (a_neg)         res_hi = -raw_hi;
    end else if (a_neg ^ b_neg) begin
      prod   = -prod;
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit with HI/LO registers.
// Divide support is built only when MDU_DIV_EN is defined.
module muldiv_unit
  import mdu_pkg::*;
(
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HiWe,
  input  logic        LoWe,
  input  logic [31:0] WData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        DivZero
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q;
  logic [31:0]      hi_q, lo_q;
  logic [31:0]      acc_q, qr_q, b_mag_q;
  logic             a_neg_q, b_neg_q;
  logic             accept;
  logic [32:0]      mul_sum;
  logic [31:0]      acc_nx, qr_nx;
  logic [31:0]      a_mag, b_mag, fix_hi, fix_lo, res_hi, res_lo;
  logic             is_div;

`ifdef MDU_DIV_EN
  logic             is_div_q, div_zero_q;
  logic [31:0]      a_q;
  logic [32:0]      div_sh, div_df;
  logic             div_ge;

  assign is_div  = is_div_q;
  assign accept  = Start && (state_q != S_CALC);
  assign DivZero = div_zero_q;
`else
  assign is_div  = 1'b0;
  assign accept  = Start && (state_q != S_CALC) && !Op[1];
  assign DivZero = 1'b0;
`endif

  assign Busy = busy_q;
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

  mdu_signfix u_signfix (
    .sgn    (Op[0]),
    .a      (A),
    .b      (B),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .a_neg  (a_neg_q),
    .b_neg  (b_neg_q),
    .is_div (is_div),
    .raw_hi (acc_nx),
    .raw_lo (qr_nx),
    .res_hi (fix_hi),
    .res_lo (fix_lo)
  );

  // One iteration step: {acc,qr} is the shifting product or remainder/quotient pair.
  always_comb begin
    mul_sum = {1'b0, acc_q} + (qr_q[0] ? {1'b0, b_mag_q} : 33'd0);
    acc_nx  = mul_sum[32:1];
    qr_nx   = {mul_sum[0], qr_q[31:1]};
    res_hi  = fix_hi;
    res_lo  = fix_lo;
`ifdef MDU_DIV_EN
    div_sh  = {acc_q, qr_q[31]};
    div_df  = div_sh - {1'b0, b_mag_q};
    div_ge  = (div_sh >= {1'b0, b_mag_q});
    if (is_div_q) begin
      acc_nx = div_ge ? div_df[31:0] : div_sh[31:0];
      qr_nx  = {qr_q[30:0], div_ge};
    end
    if (is_div_q && (b_mag_q == 32'd0)) begin
      res_hi = a_q;
      res_lo = 32'hFFFF_FFFF;
    end
`endif
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
`ifdef MDU_DIV_EN
      div_zero_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (HiWe) hi_q <= WData;
          if (LoWe) lo_q <= WData;
          if (accept) begin
            state_q    <= S_CALC;
            cnt_q      <= CNT_W'(MDU_ITER);
            busy_q     <= 1'b1;
`ifdef MDU_DIV_EN
            div_zero_q <= 1'b0;
`endif
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q    <= S_DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            hi_q       <= res_hi;
            lo_q       <= res_lo;
`ifdef MDU_DIV_EN
            div_zero_q <= is_div_q && (b_mag_q == 32'd0);
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Operand latch and iteration registers; meaningful only while in CALC.
  always_ff @(posedge Clk) begin
    if (accept) begin
      acc_q    <= '0;
      qr_q     <= a_mag;
      b_mag_q  <= b_mag;
      a_neg_q  <= Op[0] & A[31];
      b_neg_q  <= Op[0] & B[31];
`ifdef MDU_DIV_EN
      is_div_q <= Op[1];
      a_q      <= A;
`endif
    end else if (state_q == S_CALC) begin
      acc_q <= acc_nx;
      qr_q  <= qr_nx;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard testbench for muldiv_unit; divide cases follow MDU_DIV_EN.
module tb_muldiv_unit;
  import mdu_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Clrn = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] A = '0, B = '0;
  logic        HiWe = 1'b0, LoWe = 1'b0;
  logic [31:0] WData = '0;
  logic        Busy, Done, DivZero;
  logic [31:0] Hi, Lo;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  exp_t last_e;

  muldiv_unit dut (
    .Clk(Clk), .Clrn(Clrn), .Start(Start), .Op(Op), .A(A), .B(B),
    .HiWe(HiWe), .LoWe(LoWe), .WData(WData),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo), .DivZero(DivZero)
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        r;
    logic [63:0] p;
    longint      sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r.dz = 1'b0;
    case (op)
      2'b00: p = {32'd0, a} * {32'd0, b};
      2'b01: p = sa * sb;
      2'b10: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          p[31:0]  = 32'(sa / sb);
          p[63:32] = 32'(sa % sb);
        end
      end
    endcase
    if (op[1] && b == 0) r.dz = 1'b1;
    r.hi = p[63:32];
    r.lo = p[31:0];
    return r;
  endfunction

  // Drive Start for one edge; returns #1 after the accepting edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    last_e = model(op, a, b);
    exp_q.push_back(last_e);
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (!Done && lat < 40) begin
      if (Busy) bcnt++;
      @(posedge Clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat, bcnt;
    start_op(op, a, b);
    wait_done(lat, bcnt);
    check_val({tag, "_latency"}, 64'(lat), 64'd32);
    check_val({tag, "_busy_cycles"}, 64'(bcnt), 64'd32);
    @(negedge Clk);
  endtask

  // Scoreboard: compare every Done pulse against the oldest pending expectation.
  always @(negedge Clk) begin
    if (Clrn && Done) begin
      if (exp_q.size() == 0) check_val("spurious_done", 64'(Done), 64'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("hi", 64'(Hi), 64'(e.hi));
        check_val("lo", 64'(Lo), 64'(e.lo));
        check_val("divzero", 64'(DivZero), 64'(e.dz));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat, bcnt;
    logic [31:0] ref_lo, ref_hi;

    #12;
    check_val("rst_busy", 64'(Busy), 64'd0);
    check_val("rst_done", 64'(Done), 64'd0);
    check_val("rst_hi", 64'(Hi), 64'd0);
    check_val("rst_lo", 64'(Lo), 64'd0);
    check_val("rst_divzero", 64'(DivZero), 64'd0);
    @(negedge Clk); Clrn = 1'b1;

    run_op("mult_neg2x3", OP_MULT, 32'hFFFF_FFFE, 32'd3);
    check_val("mult_neg2x3_hi_const", 64'(Hi), 64'hFFFF_FFFF);
    check_val("mult_neg2x3_lo_const", 64'(Lo), 64'hFFFF_FFFA);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_val("multu_max_hi_const", 64'(Hi), 64'hFFFF_FFFE);
    run_op("mult_mixed", OP_MULT, 32'h8000_0000, 32'h7FFF_FFFF);
    run_op("multu_zero", OP_MULTU, 32'h1234_5678, 32'd0);

`ifdef MDU_DIV_EN
    run_op("div_neg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check_val("div_neg7by2_lo_const", 64'(Lo), 64'hFFFF_FFFD);
    run_op("divu_by0", OP_DIVU, 32'd5, 32'd0);
    check_val("divu_by0_dz_const", 64'(DivZero), 64'd1);
    start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check_val("dz_clear_on_start", 64'(DivZero), 64'd0);
    wait_done(lat, bcnt);
    check_val("div_ovf_latency", 64'(lat), 64'd32);
    @(negedge Clk);
    run_op("div_by0_signed", OP_DIV, 32'hFFFF_FFF0, 32'd0);
    run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd10);
    run_op("div_pos_by_neg", OP_DIV, 32'd100, 32'hFFFF_FFF9);
    run_op("mult_after_div", OP_MULT, 32'd7, 32'hFFFF_FFFF);
`else
    ref_hi = Hi; ref_lo = Lo;
    @(negedge Clk);
    Start = 1'b1; Op = OP_DIVU; A = 32'd5; B = 32'd0;
    @(posedge Clk); #1;
    Start = 1'b0;
    check_val("nodiv_busy0", 64'(Busy), 64'd0);
    repeat (3) @(posedge Clk);
    #1;
    check_val("nodiv_busy1", 64'(Busy), 64'd0);
    check_val("nodiv_done", 64'(Done), 64'd0);
    check_val("nodiv_hi", 64'(Hi), 64'(ref_hi));
    check_val("nodiv_lo", 64'(Lo), 64'(ref_lo));
    check_val("nodiv_dz", 64'(DivZero), 64'd0);
`endif

    // Register writes while idle.
    @(negedge Clk); HiWe = 1'b1; WData = 32'hA5A5_0001;
    @(negedge Clk); HiWe = 1'b0; LoWe = 1'b1; WData = 32'h5A5A_0002;
    @(negedge Clk); LoWe = 1'b0;
    check_val("mthi", 64'(Hi), 64'hA5A5_0001);
    check_val("mtlo", 64'(Lo), 64'h5A5A_0002);

    // Second Start and LoWe during CALC must be ignored.
    ref_lo = Lo;
    start_op(OP_MULTU, 32'd1234, 32'd5678);
    repeat (4) @(posedge Clk);
    @(negedge Clk); Start = 1'b1; Op = OP_MULT; A = 32'd99; B = 32'hFFFF_FF00;
    @(negedge Clk); Start = 1'b0;
    repeat (4) @(posedge Clk);
    @(negedge Clk); LoWe = 1'b1; WData = 32'hDEAD_BEEF;
    @(posedge Clk); #1;
    LoWe = 1'b0;
    check_val("calc_lowe_ignored", 64'(Lo), 64'(ref_lo));
    wait_done(lat, bcnt);
    check_val("ignore_start_done", 64'(Done), 64'd1);
    @(negedge Clk);
    repeat (40) @(posedge Clk);
    #1;
    check_val("ignore_start_no_busy", 64'(Busy), 64'd0);

    // Write and launch on the same edge; the result then overwrites both.
    @(negedge Clk);
    Start = 1'b1; Op = OP_MULT; A = 32'hFFFF_FF00; B = 32'h0001_0001;
    HiWe = 1'b1; LoWe = 1'b1; WData = 32'h0BAD_F00D;
    last_e = model(OP_MULT, 32'hFFFF_FF00, 32'h0001_0001);
    exp_q.push_back(last_e);
    @(posedge Clk); #1;
    Start = 1'b0; HiWe = 1'b0; LoWe = 1'b0;
    check_val("simul_write_hi", 64'(Hi), 64'h0BAD_F00D);
    check_val("simul_write_lo", 64'(Lo), 64'h0BAD_F00D);
    check_val("simul_busy", 64'(Busy), 64'd1);
    wait_done(lat, bcnt);
    check_val("simul_latency", 64'(lat), 64'd32);
    @(negedge Clk);

    // Asynchronous reset in the middle of CALC.
    start_op(OP_MULTU, 32'hFFFF_0000, 32'h0000_FFFF);
    repeat (14) @(posedge Clk);
    #3;
    Clrn = 1'b0;
    exp_q.delete();
    #1;
    check_val("arst_busy", 64'(Busy), 64'd0);
    check_val("arst_hi", 64'(Hi), 64'd0);
    check_val("arst_lo", 64'(Lo), 64'd0);
    check_val("arst_done", 64'(Done), 64'd0);
    @(negedge Clk); Clrn = 1'b1;
    repeat (25) @(posedge Clk);
    #1;
    check_val("arst_no_done", 64'(Done), 64'd0);
    run_op("multu_6x7", OP_MULTU, 32'd6, 32'd7);
    check_val("multu_6x7_lo_const", 64'(Lo), 64'd42);
    check_val("multu_6x7_hi_const", 64'(Hi), 64'd0);

    // Back-to-back: launch again in the DONE cycle.
    start_op(OP_MULT, 32'hFFFF_FFF6, 32'hFFFF_FFF6);
    wait_done(lat, bcnt);
    check_val("b2b_first_latency", 64'(lat), 64'd32);
    Start = 1'b1; Op = OP_MULTU; A = 32'h0001_0000; B = 32'h0003_0000;
    last_e = model(OP_MULTU, 32'h0001_0000, 32'h0003_0000);
    exp_q.push_back(last_e);
    @(posedge Clk); #1;
    Start = 1'b0;
    check_val("b2b_busy", 64'(Busy), 64'd1);
    wait_done(lat, bcnt);
    check_val("b2b_second_latency", 64'(lat), 64'd32);
    @(negedge Clk);
    repeat (3) @(posedge Clk);
    #1;

    check_val("pending_results", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
Parameters: none.
REQ-001 The module SHALL have these ports:
  Clk     in   1   clock; all state updates on rising edge.
  Clrn    in   1   reset, asynchronous, active-low.
  Start   in   1   launch operation; sampled on Clk rising edge.
  Op      in   2   00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
  A       in   32  operand rs (regfile read port a).
  B       in   32  operand rt (regfile read port b).
  HiWe    in   1   MTHI write enable.
  LoWe    in   1   MTLO write enable.
  WData   in   32  MTHI/MTLO data.
  Busy    out  1   operation in progress.
  Done    out  1   one-cycle completion pulse.
  Hi      out  32  HI register.
  Lo      out  32  LO register.
  DivZero out  1   last division had B==0.

Function
REQ-002 States SHALL be IDLE, CALC and DONE; reset state is IDLE.
REQ-003 In IDLE or DONE, Start=1 at edge N SHALL latch A, B and Op, load the 6-bit iteration counter with 32, and enter CALC.
REQ-004 Start while in CALC SHALL be ignored; latched operands SHALL NOT change.
REQ-005 CALC SHALL perform one radix-2 shift-add (multiply) or restoring-subtract (divide) step per cycle on magnitudes, decrementing the counter.
REQ-006 Busy SHALL be 1 exactly in CALC (cycles N+1..N+32); at edge N+32 Hi/Lo SHALL load the result and the state SHALL become DONE.
REQ-007 Done SHALL be 1 only in DONE (one cycle); DONE SHALL go to IDLE, or to CALC if Start=1.
REQ-008 MULT/MULTU: {Hi,Lo} SHALL equal the full 64-bit signed/unsigned product.
REQ-009 DIV/DIVU: Lo SHALL be the quotient truncated toward zero and Hi the remainder, with remainder sign equal to dividend sign.
REQ-010 B==0 on divide: Lo SHALL be 32'hFFFF_FFFF, Hi SHALL be A, DivZero SHALL be 1, and latency SHALL be unchanged.
REQ-011 DIV 32'h8000_0000 by 32'hFFFF_FFFF SHALL give Lo=32'h8000_0000, Hi=0.
REQ-012 DivZero SHALL update at the DONE transition of each divide, clear on each accepted Start, and stay 0 for multiplies.
REQ-013 HiWe/LoWe in IDLE or DONE SHALL write WData to Hi/Lo at that edge; in CALC they SHALL be ignored.
REQ-014 Simultaneous Start and HiWe/LoWe SHALL perform the write and launch the operation; the final result overwrites both registers.
REQ-015 Hi and Lo SHALL hold their values except on writes per REQ-006 and REQ-013.

Reset
REQ-016 Clrn=0 SHALL immediately force state IDLE, counter 0, Busy=0, Done=0, DivZero=0, Hi=0, Lo=0, regardless of Clk.
REQ-017 Reset during CALC SHALL abort the operation with no Done pulse; the first Start after release SHALL behave as in REQ-003.

Configuration
REQ-018 Macro MDU_DIV_EN defined: divide datapath SHALL be present and all four Op codes SHALL be supported.
REQ-019 MDU_DIV_EN undefined: Start with Op[1]=1 SHALL be ignored (no Busy, no Done, Hi/Lo unchanged), DivZero SHALL be tied 0, and no divide logic SHALL be synthesized.

Structure
REQ-020 Package mdu_pkg SHALL hold the Op encodings, the state enumeration and the constant MDU_ITER=32.
REQ-021 Sub-module mdu_signfix SHALL perform operand magnitude extraction and final two's-complement sign correction; the FSM, counter and iteration datapath SHALL stay in muldiv_unit.

Verification
REQ-022 MULT A=32'hFFFF_FFFE (-2), B=3 -> Done at N+33, Hi=32'hFFFF_FFFF, Lo=32'hFFFF_FFFA.
REQ-023 MULTU A=B=32'hFFFF_FFFF -> Hi=32'hFFFF_FFFE, Lo=32'h0000_0001; Busy high exactly 32 cycles.
REQ-024 DIV A=-7 (32'hFFFF_FFF9), B=2 -> Lo=32'hFFFF_FFFD, Hi=32'hFFFF_FFFF; DIVU A=5, B=0 -> Lo=32'hFFFF_FFFF, Hi=5, DivZero=1.
REQ-025 Start at N, second Start at N+5 with different operands, LoWe=1 at N+10 -> result of the first op only; Lo not written at N+10.
REQ-026 Clrn pulsed low at N+15 during CALC -> Busy=0, Hi=Lo=0 immediately, no Done; new MULTU 6x7 after release -> Lo=42, Hi=0.
REQ-027 Back-to-back: Start in the DONE cycle -> Busy=1 on the next cycle; both results correct in sequence.
